// File: rtl/serial_adder.sv
// serial_adder: bit-serial unsigned adder with a valid/ready handshake on both
// sides. Operands are captured in IDLE. RUN adds one bit per cycle, LSB first,
// for WIDTH cycles. The result is then held in DONE until the consumer takes it.
// Optional build macro: SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow output 'ovf' that is valid together with out_valid.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  // The counter only has to reach WIDTH-1, so WIDTH=1 still gets a one-bit counter.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Explicit two-bit encoding; the spare code 2'b11 falls back to IDLE.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q,  state_d;
  logic [WIDTH-1:0] shiftA_q, shiftA_d;
  logic [WIDTH-1:0] shiftB_q, shiftB_d;
  logic [WIDTH-1:0] sum_q,    sum_d;
  logic             carry_q,  carry_d;
  logic             cout_q,   cout_d;
  logic [CNT_W-1:0] count_q,  count_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q,    ovf_d;
`endif

  logic bitA;
  logic bitB;
  logic halfSum;
  logic halfCarry;
  logic sumBit;
  logic fullCarry;
  logic lastBit;
  logic acceptIn;
  logic releaseOut;

  // One full-adder slice built from two half-adder stages and an OR.
  always_comb begin
    bitA      = shiftA_q[0];
    bitB      = shiftB_q[0];
    halfSum   = bitA ^ bitB;
    halfCarry = bitA & bitB;
    sumBit    = halfSum ^ carry_q;
    fullCarry = halfCarry | (carry_q & halfSum);
    lastBit   = (count_q == CNT_LAST);
  end

  // The handshakes decode straight from the state register.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    acceptIn   = in_ready & in_valid;
    releaseOut = out_valid & out_ready;
  end

  // Next-state logic for the controller. Inputs are ignored when their state is not active.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: state_d = acceptIn ? RUN : IDLE;
      RUN:  state_d = lastBit ? DONE : RUN;
      DONE: state_d = releaseOut ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: load on accept, then shift and add one bit each RUN cycle.
  always_comb begin
    shiftA_d = shiftA_q;
    shiftB_d = shiftB_q;
    sum_d    = sum_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    count_d  = count_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (acceptIn) begin
          shiftA_d = a;
          shiftB_d = b;
          carry_d  = cin;
          count_d  = '0;
        end
      end
      RUN: begin
        shiftA_d = shiftA_q >> 1;
        shiftB_d = shiftB_q >> 1;
        sum_d    = sum_q >> 1;
        sum_d[WIDTH-1] = sumBit;
        carry_d  = fullCarry;
        count_d  = count_q + CNT_ONE;
        if (lastBit) begin
          cout_d = fullCarry;
`ifdef SERIAL_ADDER_OVF_EN
          // On the last slice, carry_q is the carry into the sign bit.
          ovf_d  = carry_q ^ fullCarry;
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // Controller state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers. Reset clears them all, so an aborted add leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shiftA_q <= '0;
      shiftB_q <= '0;
      sum_q    <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      shiftA_q <= shiftA_d;
      shiftB_q <= shiftB_d;
      sum_q    <= sum_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // Overflow flag register, cleared by reset like the rest of the result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder with WIDTH=8. The driver
// pushes the expected result from an arithmetic reference model. A separate
// monitor pops and compares each result on its output handshake. It also
// checks the accept-to-valid latency. Build with SERIAL_ADDER_OVF_EN defined
// to include the overflow output.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int compared   = 0;
  int mismatched = 0;
  int edgeCnt    = 0;

  logic [9:0] expQ[$];
  int         acceptQ[$];
  bit         seenValid = 1'b0;
  bit         prevValid = 1'b0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Edge counter used to timestamp accepts and result arrivals.
  always @(posedge clk) edgeCnt <= edgeCnt + 1;

  // Hard stop in case something hangs beyond every per-wait bound.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time exceeded");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: integer arithmetic for the carry, signed ranges for overflow.
  function automatic logic [9:0] refModel(input logic [7:0] x, input logic [7:0] y, input logic c);
    int total;
    int sx;
    int sy;
    int st;
    logic [7:0] s;
    logic carry;
    logic over;
    total = int'(x) + int'(y) + int'(c);
    s     = 8'(total % 256);
    carry = (total >= 256);
    sx    = (int'(x) >= 128) ? int'(x) - 256 : int'(x);
    sy    = (int'(y) >= 128) ? int'(y) - 256 : int'(y);
    st    = sx + sy + int'(c);
    over  = (st > 127) || (st < -128);
    return {over, carry, s};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Present operands and wait (bounded) until the DUT will take them at the next edge.
  task automatic applyStimulus(input logic [7:0] x, input logic [7:0] y, input logic c, output int acceptEdge);
    int waited;
    waited = 0;
    @(posedge clk); #2;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    cin = c;
    while (!in_ready && waited < 100) begin
      @(posedge clk); #2;
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL acceptTimeout: in_ready stayed 0, expected 1");
      acceptEdge = -1;
    end else begin
      acceptEdge = edgeCnt + 1;
      expQ.push_back(refModel(x, y, c));
      acceptQ.push_back(acceptEdge);
    end
  endtask

  task automatic releaseInputs();
    @(posedge clk); #2;
    in_valid = 1'b0;
  endtask

  // Wait until every queued result has been consumed and the DUT is idle again.
  task automatic waitIdle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!(expQ.size() == 0 && in_ready) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!(expQ.size() == 0 && in_ready)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL idleTimeout: %0d results pending, in_ready=%0d, expected 0 pending and 1", expQ.size(), in_ready);
    end
  endtask

  // Monitor: checks latency when out_valid rises and the result on each output handshake.
  initial begin
    logic [9:0] e;
    int lat;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
      end else begin
        if (out_valid && !prevValid) begin
          seenValid = 1'b1;
          if (acceptQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedValid: out_valid=1 with no operation pending, expected 0");
          end else begin
            lat = edgeCnt - acceptQ.pop_front();
            checkOutput("latency", lat, 8);
          end
        end
        if (out_valid && out_ready) begin
          if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpectedResult: sum=0x%0h presented, expected no result", sum);
          end else begin
            e = expQ.pop_front();
            checkOutput("sum", 32'(sum), 32'(e[7:0]));
            checkOutput("cout", 32'(cout), 32'(e[8]));
`ifdef SERIAL_ADDER_OVF_EN
            checkOutput("ovf", 32'(ovf), 32'(e[9]));
`endif
          end
        end
        prevValid = out_valid;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    int acc;
    int accB2b[4];
    int waited;
    logic [7:0] ra;
    logic [7:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("resetInReady", 32'(in_ready), 1);
    checkOutput("resetOutValid", 32'(out_valid), 0);
    checkOutput("resetSum", 32'(sum), 0);
    checkOutput("resetCout", 32'(cout), 0);

    $display("[TB] directed additions");
    applyStimulus(8'h5A, 8'h3C, 1'b0, acc);
    releaseInputs();
    checkOutput("inReadyRun", 32'(in_ready), 0);
    waitIdle();
    applyStimulus(8'hFF, 8'h01, 1'b0, acc);
    releaseInputs();
    waitIdle();
    applyStimulus(8'hFF, 8'hFF, 1'b1, acc);
    releaseInputs();
    waitIdle();

    $display("[TB] output stall");
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, acc);
    releaseInputs();
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("stallReachDone", 32'(out_valid), 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      in_valid = 1'b1;
      a   = 8'($urandom);
      b   = 8'($urandom);
      cin = 1'($urandom);
      @(negedge clk);
      checkOutput("stallOutValid", 32'(out_valid), 1);
      checkOutput("stallInReady", 32'(in_ready), 0);
      checkOutput("stallSum", 32'(sum), 32'h46);
      checkOutput("stallCout", 32'(cout), 0);
    end
    @(posedge clk); #2;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    checkOutput("idleAfterDone", 32'(in_ready), 1);
    waitIdle();

    $display("[TB] reset abort");
    applyStimulus(8'hAA, 8'h55, 1'b1, acc);
    releaseInputs();
    repeat (3) begin
      @(posedge clk); #2;
    end
    rst_n = 1'b0;
    expQ.delete();
    acceptQ.delete();
    seenValid = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abortInReady", 32'(in_ready), 1);
    checkOutput("abortOutValid", 32'(out_valid), 0);
    checkOutput("abortSum", 32'(sum), 0);
    checkOutput("abortCout", 32'(cout), 0);
    repeat (15) @(negedge clk);
    checkOutput("abortNoValid", 32'(seenValid), 0);
    applyStimulus(8'h01, 8'h02, 1'b0, acc);
    releaseInputs();
    waitIdle();

`ifdef SERIAL_ADDER_OVF_EN
    $display("[TB] overflow cases");
    applyStimulus(8'h7F, 8'h01, 1'b0, acc);
    releaseInputs();
    waitIdle();
    applyStimulus(8'h80, 8'h80, 1'b0, acc);
    releaseInputs();
    waitIdle();
    applyStimulus(8'h10, 8'h20, 1'b0, acc);
    releaseInputs();
    waitIdle();
`endif

    $display("[TB] random additions");
    for (int i = 0; i < 12; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, 1'($urandom), acc);
      releaseInputs();
      waitIdle();
    end

    $display("[TB] back-to-back");
    for (int i = 0; i < 4; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      applyStimulus(ra, rb, 1'($urandom), accB2b[i]);
    end
    releaseInputs();
    waitIdle();
    for (int i = 1; i < 4; i++) begin
      checkOutput("acceptSpacing", 32'(accB2b[i] - accB2b[i-1]), 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 1..32).
REQ-002 The block SHALL have one clock; reset is synchronous and active-low.
REQ-003 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 The block SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-005 The block SHALL have port in_valid  input  1  operands a, b and cin are valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept operands.
REQ-007 The block SHALL have port a  input  WIDTH  addend A, unsigned.
REQ-008 The block SHALL have port b  input  WIDTH  addend B, unsigned.
REQ-009 The block SHALL have port cin  input  1  carry-in.
REQ-010 The block SHALL have port out_valid  output  1  sum and cout are valid.
REQ-011 The block SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 The block SHALL have port sum  output  WIDTH  registered result, (a+b+cin) mod 2^WIDTH.
REQ-013 The block SHALL have port cout  output  1  registered carry-out of bit WIDTH-1.

Function
REQ-014 The block SHALL be an FSM with states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-015 IDLE: on in_valid&in_ready at a rising edge, the block SHALL capture a, b into shift registers, load the carry flop with cin, clear the bit counter, and enter RUN.
REQ-016 RUN: each cycle the block SHALL compute one bit LSB-first: s=a0^b0^c, c_next=(a0&b0)|(c&(a0^b0)) (two half-adder stages plus OR), shift s into the sum register from the MSB side, shift a and b right, increment the counter.
REQ-017 After exactly WIDTH RUN cycles the block SHALL enter DONE, so out_valid rises WIDTH cycles after the accepting edge.
REQ-018 cout SHALL equal the carry flop value after the final RUN cycle.
REQ-019 DONE: sum, cout and out_valid SHALL hold stable until out_valid&out_ready at an edge, after which the FSM SHALL return to IDLE (in_ready=1 the next cycle).
REQ-020 in_valid, a, b, cin SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-021 WIDTH=1 SHALL work: single RUN cycle, then DONE.
REQ-022 Minimum initiation interval SHALL be WIDTH+2 cycles (accept, WIDTH RUN, DONE with out_ready=1).
REQ-023 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-024 While rst_n=0 at an edge the block SHALL enter IDLE and clear sum, cout, carry flop, counter and shift registers to 0; in_ready=1, out_valid=0 from the first edge after reset is deasserted.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no result ever presented.

Configuration
REQ-026 With macro SERIAL_ADDER_OVF_EN defined the block SHALL add port ovf  output  1  signed (two's-complement) overflow = carry into bit WIDTH-1 XOR cout, registered, valid with out_valid, reset 0.
REQ-027 Without SERIAL_ADDER_OVF_EN the ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, cin=0, out_ready=1 -> out_valid 8 cycles after accept, sum=0x96, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 out_ready=0 for 5 cycles in DONE -> sum/cout/out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-031 rst_n=0 during RUN cycle 4 -> out_valid never asserts, sum=0x00, in_ready=1 after reset release; next operation 0x01+0x02 -> sum=0x03.
REQ-032 SERIAL_ADDER_OVF_EN defined: 0x7F+0x01 -> sum=0x80, ovf=1; 0x80+0x80 -> sum=0x00, cout=1, ovf=1; 0x10+0x20 -> ovf=0.
REQ-033 Back-to-back: in_valid held high, out_ready=1, 4 random operand pairs -> each result matches reference model, accept spacing exactly 10 cycles.
